// File: rtl/irq_counter_pkg.sv
// -----------------------------------------------------------------------------
// irq_counter_pkg
// Shared types and constants for the mapper IRQ prescale counter:
//   src_e   - tick source select (MODE[1:0])
//   dir_e   - count direction (MODE[7:6]); 00/11 halt counting
//   REG_*   - register indices on the mapper register bus
//   dir_active() - true for the two directions that actually count
// -----------------------------------------------------------------------------
package irq_counter_pkg;

    typedef enum logic [1:0] {
        SRC_CPU   = 2'd0,
        SRC_A12   = 2'd1,
        SRC_PPURD = 2'd2,
        SRC_CPUWR = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        DIR_HALT_LO = 2'b00,
        DIR_UP      = 2'b01,
        DIR_DOWN    = 2'b10,
        DIR_HALT_HI = 2'b11
    } dir_e;

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_MODE      = 3'd1;
    localparam logic [2:0] REG_DISABLE   = 3'd2;
    localparam logic [2:0] REG_ENABLE    = 3'd3;
    localparam logic [2:0] REG_PRESCALER = 3'd4;
    localparam logic [2:0] REG_COUNTER   = 3'd5;
    localparam logic [2:0] REG_XOR       = 3'd6;
    localparam logic [2:0] REG_ACK       = 3'd7;

    function automatic logic dir_active(input dir_e d);
        return (d == DIR_UP) || (d == DIR_DOWN);
    endfunction

endpackage

// File: rtl/irq_prescale_counter_if.sv
// -----------------------------------------------------------------------------
// irq_prescale_counter_if
// Mapper register bus into the IRQ counter.
//   reg_we    - decoded register write (already qualified by the mapper)
//   reg_addr  - register index 0..7
//   reg_wdata - write data
//   reg_rdata - combinational read data for reg_addr
// master: mapper decode side; slave: IRQ counter.
// -----------------------------------------------------------------------------
interface irq_prescale_counter_if #(
    parameter int unsigned DW = 8
);
    logic          reg_we;
    logic [2:0]    reg_addr;
    logic [DW-1:0] reg_wdata;
    logic [DW-1:0] reg_rdata;

    modport master (output reg_we, output reg_addr, output reg_wdata, input reg_rdata);
    modport slave  (input reg_we, input reg_addr, input reg_wdata, output reg_rdata);
endinterface

// File: rtl/irq_tick_source.sv
// -----------------------------------------------------------------------------
// irq_tick_source
// Selects the raw event that advances the IRQ prescaler.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_ce           - CPU M2 enable          (SRC_CPU, SRC_CPUWR)
//   i_ppu_ce       - PPU cycle enable       (SRC_A12, SRC_PPURD)
//   i_cpu_write    - CPU write strobe       (SRC_CPUWR)
//   i_chr_a12      - PPU address bit 12     (SRC_A12 rising edge)
//   i_chr_read     - PPU read strobe        (SRC_PPURD)
//   i_src          - source select
//   o_tick         - one-cycle raw event (not yet gated by enable/direction)
// Build option IRQ_A12_FILTER_EN: an A12 rise only counts after A12 has been
// low for at least A12_LOW_MIN consecutive ppu_ce samples.
// -----------------------------------------------------------------------------
module irq_tick_source
    import irq_counter_pkg::*;
#(
    parameter int unsigned A12_LOW_MIN = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ce,
    input  logic i_ppu_ce,
    input  logic i_cpu_write,
    input  logic i_chr_a12,
    input  logic i_chr_read,
    input  src_e i_src,
    output logic o_tick
);

    logic r_a12_prev;
    logic w_a12_rise;

    // A12 is only meaningful when sampled on a PPU cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a12_prev <= 1'b0;
        end else if (i_ppu_ce) begin
            r_a12_prev <= i_chr_a12;
        end
    end

`ifdef IRQ_A12_FILTER_EN
    localparam int unsigned LW = (A12_LOW_MIN < 2) ? 1 : $clog2(A12_LOW_MIN + 1);
    localparam logic [LW-1:0] LOW_MIN = LW'(A12_LOW_MIN);

    logic [LW-1:0] r_low_cnt;

    // Saturating count of consecutive low samples; any high sample restarts it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_low_cnt <= '0;
        end else if (i_ppu_ce) begin
            if (i_chr_a12) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt < LOW_MIN) begin
                r_low_cnt <= r_low_cnt + 1'b1;
            end
        end
    end

    assign w_a12_rise = i_ppu_ce && i_chr_a12 && !r_a12_prev && (r_low_cnt >= LOW_MIN);
`else
    assign w_a12_rise = i_ppu_ce && i_chr_a12 && !r_a12_prev;

    // The unfiltered detector has no use for the low-time threshold.
    if (A12_LOW_MIN == 0) begin : g_low_min_unused
    end
`endif

    always_comb begin
        o_tick = 1'b0;
        case (i_src)
            SRC_CPU:   o_tick = i_ce;
            SRC_A12:   o_tick = w_a12_rise;
            SRC_PPURD: o_tick = i_ppu_ce && i_chr_read;
            SRC_CPUWR: o_tick = i_ce && i_cpu_write;
            default:   o_tick = 1'b0;
        endcase
    end

endmodule

// File: rtl/irq_prescale_counter.sv
// -----------------------------------------------------------------------------
// irq_prescale_counter
// Mapper IRQ timer: selectable tick source -> prescaler -> event counter ->
// pending flag. PRESCALER/COUNTER loads are XOR-obfuscated with the XOR reg.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   ce            - CPU M2 enable
//   ppu_ce        - PPU cycle enable
//   cpu_write     - CPU write strobe
//   chr_a12       - PPU address bit 12
//   chr_read      - PPU read strobe
//   bus           - register bus (reg_we/reg_addr/reg_wdata/reg_rdata)
//   irq           - pending && enabled
// Registers: 0 CTRL, 1 MODE, 2 DISABLE, 3 ENABLE, 4 PRESCALER, 5 COUNTER,
//            6 XOR, 7 ACK. MODE: [1:0] src, [2] short prescale,
//            [3] auto-reload, [7:6] direction. DW must be at least 8.
// Build option IRQ_A12_FILTER_EN enables the A12 low-time filter.
// -----------------------------------------------------------------------------
module irq_prescale_counter
    import irq_counter_pkg::*;
#(
    parameter int unsigned DW          = 8,
    parameter int unsigned PRESCALE_W  = 8,
    parameter int unsigned COUNT_W     = 8,
    parameter int unsigned A12_LOW_MIN = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ce,
    input  logic                   ppu_ce,
    input  logic                   cpu_write,
    input  logic                   chr_a12,
    input  logic                   chr_read,
    irq_prescale_counter_if.slave  bus,
    output logic                   irq
);

    logic [DW-1:0]         r_mode;
    logic [DW-1:0]         r_xor;
    logic [PRESCALE_W-1:0] r_prescaler;
    logic [COUNT_W-1:0]    r_counter;
    logic [COUNT_W-1:0]    r_reload;
    logic                  r_enable;
    logic                  r_pending;

    src_e                  w_src;
    dir_e                  w_dir;
    logic                  w_up;
    logic                  w_src_tick;
    logic                  w_tick;
    logic [DW-1:0]         w_load;
    logic                  w_wr_ctrl, w_wr_mode, w_wr_dis, w_wr_en;
    logic                  w_wr_pre, w_wr_cnt, w_wr_xor, w_wr_ack;
    logic                  w_disable, w_enable_set;
    logic                  w_pre_term, w_cnt_term, w_cnt_step, w_set_pending;
    logic [PRESCALE_W-1:0] w_pre_next;
    logic [COUNT_W-1:0]    w_cnt_next;

    assign w_src = src_e'(r_mode[1:0]);
    assign w_dir = dir_e'(r_mode[7:6]);
    assign w_up  = (w_dir == DIR_UP);

    irq_tick_source #(
        .A12_LOW_MIN (A12_LOW_MIN)
    ) u_tick_source (
        .i_clk       (clk),
        .i_rst_n     (reset_n),
        .i_ce        (ce),
        .i_ppu_ce    (ppu_ce),
        .i_cpu_write (cpu_write),
        .i_chr_a12   (chr_a12),
        .i_chr_read  (chr_read),
        .i_src       (w_src),
        .o_tick      (w_src_tick)
    );

    assign w_wr_ctrl = bus.reg_we && (bus.reg_addr == REG_CTRL);
    assign w_wr_mode = bus.reg_we && (bus.reg_addr == REG_MODE);
    assign w_wr_dis  = bus.reg_we && (bus.reg_addr == REG_DISABLE);
    assign w_wr_en   = bus.reg_we && (bus.reg_addr == REG_ENABLE);
    assign w_wr_pre  = bus.reg_we && (bus.reg_addr == REG_PRESCALER);
    assign w_wr_cnt  = bus.reg_we && (bus.reg_addr == REG_COUNTER);
    assign w_wr_xor  = bus.reg_we && (bus.reg_addr == REG_XOR);
    assign w_wr_ack  = bus.reg_we && (bus.reg_addr == REG_ACK);

    assign w_load       = bus.reg_wdata ^ r_xor;
    assign w_disable    = (w_wr_ctrl && !bus.reg_wdata[0]) || w_wr_dis;
    assign w_enable_set = (w_wr_ctrl &&  bus.reg_wdata[0]) || w_wr_en;

    // A disabling write swallows any tick landing in the same cycle, so the
    // counter holds and no pending edge can sneak past the clear.
    assign w_tick = w_src_tick && r_enable && dir_active(w_dir) && !w_disable;

    always_comb begin
        w_pre_term = 1'b0;
        if (w_up) begin
            w_pre_term = r_mode[2] ? (&r_prescaler[2:0]) : (&r_prescaler);
        end else begin
            w_pre_term = r_mode[2] ? (~|r_prescaler[2:0]) : (~|r_prescaler);
        end
        w_pre_next = w_up ? (r_prescaler + PRESCALE_W'(1)) : (r_prescaler - PRESCALE_W'(1));

        w_cnt_term = w_up ? (&r_counter) : (~|r_counter);
        if (w_cnt_term && r_mode[3]) begin
            w_cnt_next = r_reload;
        end else begin
            w_cnt_next = w_up ? (r_counter + COUNT_W'(1)) : (r_counter - COUNT_W'(1));
        end
    end

    assign w_cnt_step    = w_tick && w_pre_term;
    assign w_set_pending = w_cnt_step && w_cnt_term;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode      <= '0;
            r_xor       <= '0;
            r_prescaler <= '0;
            r_counter   <= '0;
            r_reload    <= '0;
            r_enable    <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            if (w_wr_mode) begin
                r_mode <= bus.reg_wdata;
            end
            if (w_wr_xor) begin
                r_xor <= bus.reg_wdata;
            end

            if (w_wr_cnt) begin
                r_counter <= COUNT_W'(w_load);
                r_reload  <= COUNT_W'(w_load);
            end else if (w_cnt_step) begin
                r_counter <= w_cnt_next;
            end

            if (w_disable) begin
                r_enable    <= 1'b0;
                r_pending   <= 1'b0;
                r_prescaler <= '0;
            end else begin
                if (w_enable_set) begin
                    r_enable <= 1'b1;
                end
                if (w_wr_pre) begin
                    r_prescaler <= PRESCALE_W'(w_load);
                end else if (w_tick) begin
                    r_prescaler <= w_pre_next;
                end
                // A fresh terminal wins over an ACK in the same cycle.
                if (w_set_pending) begin
                    r_pending <= 1'b1;
                end else if (w_wr_ack) begin
                    r_pending <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.reg_rdata = '0;
        case (bus.reg_addr)
            REG_CTRL:      bus.reg_rdata = DW'({r_pending, r_enable});
            REG_MODE:      bus.reg_rdata = r_mode;
            REG_PRESCALER: bus.reg_rdata = DW'(r_prescaler);
            REG_COUNTER:   bus.reg_rdata = DW'(r_counter);
            REG_XOR:       bus.reg_rdata = r_xor;
            default:       bus.reg_rdata = '0;
        endcase
    end

    assign irq = r_pending && r_enable;

endmodule

// File: tb/tb_irq_prescale_counter.sv
// -----------------------------------------------------------------------------
// tb_irq_prescale_counter
// Directed checks of the IRQ prescale counter with hand-computed expectations.
// A12 expectations follow IRQ_A12_FILTER_EN (A12_LOW_MIN = 3).
// -----------------------------------------------------------------------------
module tb_irq_prescale_counter;
    import irq_counter_pkg::*;

    logic clk;
    logic reset_n;
    logic ce;
    logic ppu_ce;
    logic cpu_write;
    logic chr_a12;
    logic chr_read;
    logic irq;

    int unsigned n_total;
    int unsigned n_bad;

    irq_prescale_counter_if #(.DW(8)) bus ();

    irq_prescale_counter #(
        .DW          (8),
        .PRESCALE_W  (8),
        .COUNT_W     (8),
        .A12_LOW_MIN (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .ppu_ce    (ppu_ce),
        .cpu_write (cpu_write),
        .chr_a12   (chr_a12),
        .chr_read  (chr_read),
        .bus       (bus),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus.reg_addr = a;
        #1;
        d = bus.reg_rdata;
        check_eq(tag, 32'(d), 32'(exp));
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.reg_we    = 1'b1;
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        @(posedge clk);
        #1;
        bus.reg_we = 1'b0;
    endtask

    task automatic tick_ce(input int unsigned n, input logic wr_strobe);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            ce        = 1'b1;
            cpu_write = wr_strobe;
            @(posedge clk);
            #1;
            ce        = 1'b0;
            cpu_write = 1'b0;
        end
    endtask

    task automatic ppu(input logic a12, input logic rd);
        @(negedge clk);
        ppu_ce   = 1'b1;
        chr_a12  = a12;
        chr_read = rd;
        @(posedge clk);
        #1;
        ppu_ce   = 1'b0;
        chr_read = 1'b0;
    endtask

`ifdef IRQ_A12_FILTER_EN
    localparam logic [7:0] A12_PRE_1 = 8'hFF;
    localparam logic [7:0] A12_CNT_1 = 8'h00;
    localparam logic [7:0] A12_PRE_2 = 8'h00;
`else
    localparam logic [7:0] A12_PRE_1 = 8'h00;
    localparam logic [7:0] A12_CNT_1 = 8'h01;
    localparam logic [7:0] A12_PRE_2 = 8'h01;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total       = 0;
        n_bad         = 0;
        reset_n       = 1'b0;
        ce            = 1'b0;
        ppu_ce        = 1'b0;
        cpu_write     = 1'b0;
        chr_a12       = 1'b0;
        chr_read      = 1'b0;
        bus.reg_we    = 1'b0;
        bus.reg_addr  = 3'd0;
        bus.reg_wdata = 8'h00;

        // Reset state
        #25;
        check_eq("rst_irq", 32'(irq), 32'd0);
        chk_reg("rst_ctrl", REG_CTRL, 8'h00);
        chk_reg("rst_mode", REG_MODE, 8'h00);
        chk_reg("rst_pre", REG_PRESCALER, 8'h00);
        chk_reg("rst_cnt", REG_COUNTER, 8'h00);
        chk_reg("rst_xor", REG_XOR, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // Up count from CPU ce: terminal on the second tick
        wr(REG_MODE, 8'h40);
        wr(REG_PRESCALER, 8'hFE);
        wr(REG_COUNTER, 8'hFF);
        wr(REG_ENABLE, 8'h00);
        chk_reg("en_ctrl", REG_CTRL, 8'h01);
        tick_ce(1, 1'b0);
        check_eq("up_t1_irq", 32'(irq), 32'd0);
        chk_reg("up_t1_pre", REG_PRESCALER, 8'hFF);
        tick_ce(1, 1'b0);
        check_eq("up_t2_irq", 32'(irq), 32'd1);
        chk_reg("up_t2_cnt", REG_COUNTER, 8'h00);
        chk_reg("up_t2_pre", REG_PRESCALER, 8'h00);
        chk_reg("up_t2_ctrl", REG_CTRL, 8'h03);
        wr(REG_ACK, 8'h00);
        check_eq("ack_irq", 32'(irq), 32'd0);
        chk_reg("ack_ctrl", REG_CTRL, 8'h01);

        // XOR-obfuscated loads, down count
        wr(REG_CTRL, 8'h00);
        chk_reg("ctrl_dis", REG_CTRL, 8'h00);
        wr(REG_XOR, 8'h5A);
        wr(REG_COUNTER, 8'h5B);
        chk_reg("xor_cnt", REG_COUNTER, 8'h01);
        wr(REG_MODE, 8'h80);
        chk_reg("mode_rb", REG_MODE, 8'h80);
        wr(REG_COUNTER, 8'h5A);
        wr(REG_PRESCALER, 8'h5A);
        chk_reg("xor_pre", REG_PRESCALER, 8'h00);
        wr(REG_CTRL, 8'h01);
        tick_ce(1, 1'b0);
        check_eq("dn_irq", 32'(irq), 32'd1);
        chk_reg("dn_cnt", REG_COUNTER, 8'hFF);
        chk_reg("dn_pre", REG_PRESCALER, 8'hFF);
        chk_reg("xor_rb", REG_XOR, 8'h5A);

        // Auto-reload, short down prescale: terminals at ticks 1, 9, 17, 25
        wr(REG_DISABLE, 8'h00);
        check_eq("dis_irq", 32'(irq), 32'd0);
        wr(REG_XOR, 8'h00);
        wr(REG_MODE, 8'h8C);
        wr(REG_PRESCALER, 8'h00);
        wr(REG_COUNTER, 8'h03);
        wr(REG_CTRL, 8'h01);
        tick_ce(24, 1'b0);
        check_eq("ar_24_irq", 32'(irq), 32'd0);
        chk_reg("ar_24_cnt", REG_COUNTER, 8'h00);
        chk_reg("ar_24_pre", REG_PRESCALER, 8'hE8);
        tick_ce(1, 1'b0);
        check_eq("ar_25_irq", 32'(irq), 32'd1);
        chk_reg("ar_25_cnt", REG_COUNTER, 8'h03);
        chk_reg("ar_25_pre", REG_PRESCALER, 8'hE7);
        wr(REG_ACK, 8'h00);
        check_eq("ar_ack_irq", 32'(irq), 32'd0);
        chk_reg("ar_ack_ctrl", REG_CTRL, 8'h01);
        chk_reg("ar_ack_cnt", REG_COUNTER, 8'h03);

        // Short up prescale: 05 -> 08, terminal at 07
        wr(REG_DISABLE, 8'h00);
        wr(REG_MODE, 8'h44);
        wr(REG_PRESCALER, 8'h05);
        wr(REG_COUNTER, 8'h10);
        wr(REG_ENABLE, 8'h00);
        tick_ce(2, 1'b0);
        chk_reg("sh_2_cnt", REG_COUNTER, 8'h10);
        chk_reg("sh_2_pre", REG_PRESCALER, 8'h07);
        tick_ce(1, 1'b0);
        chk_reg("sh_3_cnt", REG_COUNTER, 8'h11);
        chk_reg("sh_3_pre", REG_PRESCALER, 8'h08);
        check_eq("sh_3_irq", 32'(irq), 32'd0);

        // Disable in the same cycle as a terminal tick
        wr(REG_DISABLE, 8'h00);
        wr(REG_MODE, 8'h40);
        wr(REG_PRESCALER, 8'hFF);
        wr(REG_COUNTER, 8'hFF);
        wr(REG_ENABLE, 8'h00);
        @(negedge clk);
        ce            = 1'b1;
        bus.reg_we    = 1'b1;
        bus.reg_addr  = REG_DISABLE;
        bus.reg_wdata = 8'h00;
        @(posedge clk);
        #1;
        ce         = 1'b0;
        bus.reg_we = 1'b0;
        check_eq("dt_irq", 32'(irq), 32'd0);
        chk_reg("dt_ctrl", REG_CTRL, 8'h00);
        chk_reg("dt_pre", REG_PRESCALER, 8'h00);
        chk_reg("dt_cnt", REG_COUNTER, 8'hFF);
        tick_ce(1, 1'b0);
        check_eq("dt_next_irq", 32'(irq), 32'd0);

        // Asynchronous reset mid-count
        wr(REG_ENABLE, 8'h00);
        tick_ce(3, 1'b0);
        chk_reg("mr_pre", REG_PRESCALER, 8'h03);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("mr_irq", 32'(irq), 32'd0);
        chk_reg("mr_rst_pre", REG_PRESCALER, 8'h00);
        chk_reg("mr_rst_cnt", REG_COUNTER, 8'h00);
        chk_reg("mr_rst_mode", REG_MODE, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        tick_ce(1, 1'b0);
        chk_reg("mr_post_pre", REG_PRESCALER, 8'h00);
        chk_reg("mr_post_ctrl", REG_CTRL, 8'h00);

        // A12 rising edge source
        wr(REG_MODE, 8'h41);
        wr(REG_PRESCALER, 8'hFF);
        wr(REG_COUNTER, 8'h00);
        wr(REG_ENABLE, 8'h00);
        ppu(1'b0, 1'b0);
        ppu(1'b0, 1'b0);
        ppu(1'b1, 1'b0);
        chk_reg("a12_lo2_pre", REG_PRESCALER, A12_PRE_1);
        chk_reg("a12_lo2_cnt", REG_COUNTER, A12_CNT_1);
        ppu(1'b1, 1'b0);
        chk_reg("a12_hold_pre", REG_PRESCALER, A12_PRE_1);
        ppu(1'b0, 1'b0);
        ppu(1'b0, 1'b0);
        ppu(1'b0, 1'b0);
        ppu(1'b1, 1'b0);
        chk_reg("a12_lo3_pre", REG_PRESCALER, A12_PRE_2);
        chk_reg("a12_lo3_cnt", REG_COUNTER, 8'h01);

        // PPU read source
        wr(REG_MODE, 8'h42);
        wr(REG_PRESCALER, 8'hFF);
        wr(REG_COUNTER, 8'h00);
        ppu(1'b0, 1'b0);
        chk_reg("ppurd_no_pre", REG_PRESCALER, 8'hFF);
        ppu(1'b0, 1'b1);
        chk_reg("ppurd_pre", REG_PRESCALER, 8'h00);
        chk_reg("ppurd_cnt", REG_COUNTER, 8'h01);

        // CPU write source, then halted direction
        wr(REG_MODE, 8'h43);
        wr(REG_PRESCALER, 8'hFF);
        tick_ce(1, 1'b0);
        chk_reg("cpuwr_no_pre", REG_PRESCALER, 8'hFF);
        tick_ce(1, 1'b1);
        chk_reg("cpuwr_pre", REG_PRESCALER, 8'h00);
        chk_reg("cpuwr_cnt", REG_COUNTER, 8'h02);
        wr(REG_MODE, 8'h03);
        tick_ce(2, 1'b1);
        chk_reg("halt_pre", REG_PRESCALER, 8'h00);
        chk_reg("halt_cnt", REG_COUNTER, 8'h02);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
